// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: access-size codes, LSU state encoding and
// the alignment rule used by the MEM-stage load/store unit.
package mips_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // Size code 11 is treated as a word, like 10.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic r;
    r = 1'b0;
    if (size == SIZE_W || size == 2'b11) r = (lo != 2'b00);
    else if (size == SIZE_H) r = lo[0];
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / replicated write data, and
// load lane extraction with sign or zero extension.
module lsu_align
  import mips_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_lo_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_lane_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_lo_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic signed [7:0]  ld_b;
  logic signed [15:0] ld_h;

  always_comb begin
    st_be_o   = 4'b1111;
    st_lane_o = st_data_i;
    case (st_size_i)
      SIZE_B: begin
        st_be_o   = 4'b0001 << st_lo_i;
        st_lane_o = {4{st_data_i[7:0]}};
      end
      SIZE_H: begin
        st_be_o   = 4'b0011 << st_lo_i;
        st_lane_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_b = rdata_i[{ld_lo_i, 3'b000} +: 8];
  assign ld_h = rdata_i[{ld_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    ld_data_o = rdata_i;
    case (ld_size_i)
      SIZE_B:  ld_data_o = ld_unsigned_i ? {24'd0, ld_b} : 32'(ld_b);
      SIZE_H:  ld_data_o = ld_unsigned_i ? {16'd0, ld_h} : 32'(ld_h);
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues one registered req/ack transaction per
// aligned memory op, stalls the pipeline until it completes or times out.
module mem_lsu
  import mips_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [31:0]       ex_alu_result,
  output logic [31:0]       mem_data,
  output logic              lsu_stall,
  output logic              misalign,
  output logic              bus_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [3:0]        dmem_be,
  output logic [ADDR_W-3:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              req_q, req_d, we_q, we_d, load_q, load_d, uns_q, uns_d;
  logic              berr_q, berr_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]        size_q, size_d, lo_q, lo_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              memop, mis, stall_c;
  logic [31:0]       mem_data_c, al_wdata, al_ldata;
  logic [3:0]        al_be;
  logic              unused_addr;

  assign unused_addr = ^ex_addr[31:ADDR_W];
  assign memop = ex_valid & (ex_memread | ex_memwrite);
  assign mis   = memop & is_misaligned(ex_size, ex_addr[1:0]);

  // Store lanes come from the live EX/MEM fields; load formatting uses the
  // fields captured at issue.
  lsu_align u_align (
    .st_size_i     (ex_size),
    .st_lo_i       (ex_addr[1:0]),
    .st_data_i     (ex_wdata),
    .st_be_o       (al_be),
    .st_lane_o     (al_wdata),
    .ld_size_i     (size_q),
    .ld_lo_i       (lo_q),
    .ld_unsigned_i (uns_q),
    .rdata_i       (dmem_rdata),
    .ld_data_o     (al_ldata)
  );

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    load_d     = load_q;
    uns_d      = uns_q;
    berr_d     = berr_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    size_d     = size_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    stall_c    = 1'b0;
    mem_data_c = ex_alu_result;
    case (state_q)
      LSU_IDLE: begin
        if (mis) begin
          mem_data_c = 32'd0;
        end else if (memop) begin
          stall_c = 1'b1;
          req_d   = 1'b1;
          we_d    = ~ex_memread;
          load_d  = ex_memread;
          uns_d   = ex_unsigned;
          size_d  = ex_size;
          lo_d    = ex_addr[1:0];
          be_d    = al_be;
          addr_d  = ex_addr[ADDR_W-1:2];
          wdata_d = al_wdata;
          rdata_d = 32'd0;
          berr_d  = 1'b0;
          cnt_d   = 8'd0;
          state_d = LSU_BUSY;
        end
      end
      LSU_BUSY: begin
        stall_c = 1'b1;
        // An ack on the last allowed cycle still counts as success.
        if (dmem_ack) begin
          req_d   = 1'b0;
          rdata_d = load_q ? al_ldata : 32'd0;
          state_d = LSU_DONE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          rdata_d = 32'd0;
          berr_d  = 1'b1;
          state_d = LSU_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      LSU_DONE: begin
        mem_data_c = load_q ? rdata_q : ex_alu_result;
        state_d    = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      load_q  <= 1'b0;
      uns_q   <= 1'b0;
      berr_q  <= 1'b0;
      be_q    <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      size_q  <= 2'd0;
      lo_q    <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      load_q  <= load_d;
      uns_q   <= uns_d;
      berr_q  <= berr_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_data   = mem_data_c;
  assign lsu_stall  = rst_n & stall_c;
  assign misalign   = rst_n & (state_q == LSU_IDLE) & mis;
  assign bus_err    = rst_n & (state_q == LSU_DONE) & berr_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_be    = be_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: transaction-level model of the expected cycle
// sequence per op, one compare process, plus hand-computed literal checks.
module tb_mem_lsu;

  localparam int ADDR_W = 11;
  localparam int TMO    = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ex_valid = 0, ex_memread = 0, ex_memwrite = 0, ex_unsigned = 0;
  logic [1:0]        ex_size = 0;
  logic [31:0]       ex_addr = 0, ex_wdata = 0, ex_alu_result = 0;
  logic [31:0]       mem_data;
  logic              lsu_stall, misalign, bus_err, dmem_req, dmem_we;
  logic [3:0]        dmem_be;
  logic [ADDR_W-3:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack = 0;
  logic [31:0]       dmem_rdata = 0;

  mem_lsu #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_size(ex_size), .ex_unsigned(ex_unsigned),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_alu_result(ex_alu_result),
    .mem_data(mem_data), .lsu_stall(lsu_stall), .misalign(misalign), .bus_err(bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  logic              chk_en = 0;
  logic              exp_stall = 0, exp_req = 0, exp_we = 0, exp_mis = 0, exp_berr = 0, exp_md_vld = 0;
  logic [3:0]        exp_be = 0;
  logic [ADDR_W-3:0] exp_addr = 0;
  logic [31:0]       exp_wd = 0, exp_md = 0;

  int                req_cnt = 0, stall_cnt = 0;
  logic [3:0]        last_be = 0;
  logic [31:0]       last_wd = 0;
  logic              last_we = 0;
  logic [ADDR_W-3:0] last_addr = 0;

  localparam int L_MD = 0, L_MIS = 1, L_BERR = 2, L_REQN = 3, L_STALLN = 4, L_BE = 5,
                 L_WD = 6, L_WE = 7, L_ADDR = 8, L_REQ = 9, L_STALL = 10, L_OBE = 11,
                 L_OWD = 12, L_OADDR = 13, L_OWE = 14;
  int          lit_sel[8];
  logic [31:0] lit_exp[8];
  string       lit_nm[8];
  int          lit_n = 0, lit_seq = 0, lit_seen = 0, lit_req0 = 0, lit_stall0 = 0;

  // ---------------- behavioural model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    return 4'(((1 << nbytes(sz)) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = nbytes(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] mask, v;
    int n;
    n = nbytes(sz);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v = (rd >> (8 * (a % 4))) & mask;
    if (!uns && n < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- compare process ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lit_act(input int s);
    case (s)
      L_MD:     return mem_data;
      L_MIS:    return 32'(misalign);
      L_BERR:   return 32'(bus_err);
      L_REQN:   return 32'(req_cnt - lit_req0);
      L_STALLN: return 32'(stall_cnt - lit_stall0);
      L_BE:     return 32'(last_be);
      L_WD:     return last_wd;
      L_WE:     return 32'(last_we);
      L_ADDR:   return 32'(last_addr);
      L_REQ:    return 32'(dmem_req);
      L_STALL:  return 32'(lsu_stall);
      L_OBE:    return 32'(dmem_be);
      L_OWD:    return dmem_wdata;
      L_OADDR:  return 32'(dmem_addr);
      L_OWE:    return 32'(dmem_we);
      default:  return 32'hXXXX_XXXX;
    endcase
  endfunction

  always @(negedge clk) begin
    if (lit_seq != lit_seen) begin
      for (int i = 0; i < lit_n; i++) chk(lit_nm[i], lit_act(lit_sel[i]), lit_exp[i]);
      lit_seen = lit_seq;
    end
    if (chk_en) begin
      chk("lsu_stall", 32'(lsu_stall), 32'(exp_stall));
      chk("dmem_req", 32'(dmem_req), 32'(exp_req));
      chk("misalign", 32'(misalign), 32'(exp_mis));
      chk("bus_err", 32'(bus_err), 32'(exp_berr));
      if (exp_req) begin
        chk("dmem_we", 32'(dmem_we), 32'(exp_we));
        chk("dmem_be", 32'(dmem_be), 32'(exp_be));
        chk("dmem_addr", 32'(dmem_addr), 32'(exp_addr));
        if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wd);
      end
      if (exp_md_vld) chk("mem_data", mem_data, exp_md);
    end
    if (dmem_req) begin
      req_cnt++;
      last_be   = dmem_be;
      last_wd   = dmem_wdata;
      last_we   = dmem_we;
      last_addr = dmem_addr;
    end
    if (lsu_stall) stall_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic mark();
    lit_n = 0;
    lit_req0 = req_cnt;
    lit_stall0 = stall_cnt;
  endtask

  task automatic lit(input string nm, input int s, input logic [31:0] e);
    lit_nm[lit_n] = nm;
    lit_sel[lit_n] = s;
    lit_exp[lit_n] = e;
    lit_n++;
  endtask

  task automatic arm();
    lit_seq++;
  endtask

  // ackw: BUSY cycle (1-based) on which memory acks; 0 = never.
  task automatic run_op(input logic vld, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] alu, input logic [31:0] rdat, input int ackw);
    logic timed_out;
    @(posedge clk); #1;
    ex_valid = vld; ex_memread = rd; ex_memwrite = wr; ex_size = sz; ex_unsigned = uns;
    ex_addr = a; ex_wdata = wd; ex_alu_result = alu; dmem_rdata = rdat; dmem_ack = 0;
    exp_mis = 0; exp_berr = 0; exp_req = 0; exp_md_vld = 0;
    if (!(vld && (rd || wr))) begin
      exp_stall = 0; exp_md_vld = 1; exp_md = alu;
    end else if (m_mis(sz, a)) begin
      exp_stall = 0; exp_mis = 1; exp_md_vld = 1; exp_md = 32'd0;
    end else begin
      exp_stall = 1;
      for (int i = 1; i <= TMO; i++) begin
        @(posedge clk); #1;
        exp_req = 1; exp_we = !rd; exp_be = m_be(sz, a);
        exp_addr = a[ADDR_W-1:2]; exp_wd = m_wdata(sz, wd);
        dmem_ack = (i == ackw);
        if (i == ackw) break;
      end
      @(posedge clk); #1;
      dmem_ack = 0;
      timed_out = !(ackw >= 1 && ackw <= TMO);
      exp_req = 0; exp_stall = 0; exp_berr = timed_out; exp_md_vld = 1;
      exp_md = rd ? (timed_out ? 32'd0 : m_load(sz, uns, a, rdat)) : alu;
    end
  endtask

  initial begin
    #1;
    mark();
    lit("rst_req", L_REQ, 0); lit("rst_stall", L_STALL, 0); lit("rst_we", L_OWE, 0);
    lit("rst_be", L_OBE, 0); lit("rst_addr", L_OADDR, 0); lit("rst_wdata", L_OWD, 0);
    lit("rst_mis", L_MIS, 0); lit("rst_berr", L_BERR, 0);
    arm();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    exp_stall = 0; exp_req = 0; exp_mis = 0; exp_berr = 0; exp_md_vld = 1; exp_md = 0;
    chk_en = 1;

    // Non-memory pass-through
    run_op(1, 0, 0, 2'b10, 0, 32'h0000_0006, 0, 32'h1234_5678, 0, 0);

    // LW 0x10, ack on third request cycle
    mark();
    run_op(1, 1, 0, 2'b10, 0, 32'h10, 0, 32'h5555_0000, 32'hDEAD_BEEF, 3);
    lit("lw_data", L_MD, 32'hDEAD_BEEF); lit("lw_reqcyc", L_REQN, 3);
    lit("lw_addr", L_ADDR, 4); lit("lw_we", L_WE, 0); lit("lw_stallcyc", L_STALLN, 4);
    arm();

    // Zero-wait LW
    mark();
    run_op(1, 1, 0, 2'b11, 0, 32'h24, 0, 0, 32'h0BAD_F00D, 1);
    lit("lw0_data", L_MD, 32'h0BAD_F00D); lit("lw0_stallcyc", L_STALLN, 2);
    lit("lw0_reqcyc", L_REQN, 1);
    arm();

    // Byte/half loads with sign and zero extension
    mark(); run_op(1, 1, 0, 2'b00, 0, 32'h13, 0, 0, 32'h8011_2233, 1);
    lit("lb_data", L_MD, 32'hFFFF_FF80); arm();
    mark(); run_op(1, 1, 0, 2'b00, 1, 32'h13, 0, 0, 32'h8011_2233, 2);
    lit("lbu_data", L_MD, 32'h0000_0080); arm();
    mark(); run_op(1, 1, 0, 2'b01, 0, 32'h2, 0, 0, 32'h8011_2233, 1);
    lit("lh_data", L_MD, 32'hFFFF_8011); arm();
    mark(); run_op(1, 1, 0, 2'b01, 1, 32'h2, 0, 0, 32'h8011_2233, 1);
    lit("lhu_data", L_MD, 32'h0000_8011); arm();
    run_op(1, 1, 0, 2'b00, 0, 32'h11, 0, 0, 32'h8011_2233, 1);
    run_op(1, 1, 0, 2'b01, 0, 32'h0, 0, 0, 32'h8011_7233, 1);

    // Stores
    mark(); run_op(1, 0, 1, 2'b00, 0, 32'h5, 32'h0000_00AB, 32'hA1A1_0005, 0, 1);
    lit("sb_be", L_BE, 4'b0010); lit("sb_wdata", L_WD, 32'hABAB_ABAB);
    lit("sb_we", L_WE, 1); lit("sb_alu", L_MD, 32'hA1A1_0005); arm();
    mark(); run_op(1, 0, 1, 2'b01, 0, 32'h6, 32'hFFFF_1234, 0, 0, 2);
    lit("sh_be", L_BE, 4'b1100); lit("sh_wdata", L_WD, 32'h1234_1234); arm();
    run_op(1, 0, 1, 2'b10, 0, 32'h1FC, 32'hCAFE_BABE, 32'h77, 0, 1);

    // Both read and write: treated as a load
    run_op(1, 1, 1, 2'b10, 0, 32'h8, 32'h1111_1111, 0, 32'h2468_ACE0, 1);
    // ex_valid low with memread set: no request
    run_op(0, 1, 0, 2'b10, 0, 32'h8, 0, 32'h0000_0099, 0, 1);

    // Misaligned accesses
    mark(); run_op(1, 1, 0, 2'b10, 0, 32'h6, 0, 32'h0000_0006, 0, 1);
    lit("mis_flag", L_MIS, 1); lit("mis_data", L_MD, 0); lit("mis_noreq", L_REQN, 0);
    lit("mis_stall", L_STALL, 0); arm();
    run_op(1, 1, 0, 2'b01, 0, 32'h3, 0, 32'h3, 0, 1);
    run_op(1, 0, 1, 2'b10, 0, 32'h2, 32'h5, 32'h2, 0, 1);

    // Timeout, then ack on the last permitted cycle, then normal op
    mark(); run_op(1, 1, 0, 2'b10, 0, 32'h40, 0, 32'h4444, 32'hFFFF_FFFF, 0);
    lit("tmo_berr", L_BERR, 1); lit("tmo_data", L_MD, 0); lit("tmo_reqcyc", L_REQN, TMO); arm();
    run_op(1, 1, 0, 2'b10, 0, 32'h44, 0, 0, 32'h1357_9BDF, TMO);
    run_op(1, 0, 1, 2'b00, 0, 32'h7, 32'h0000_00C3, 32'h7, 0, 0);
    run_op(1, 1, 0, 2'b10, 0, 32'h48, 0, 0, 32'h0F0F_0F0F, 1);

    // Reset asserted mid-request
    @(posedge clk); #1;
    chk_en = 0;
    ex_valid = 1; ex_memread = 1; ex_memwrite = 0; ex_size = 2'b10; ex_addr = 32'h20;
    dmem_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    mark(); lit("busy_req", L_REQ, 1); lit("busy_stall", L_STALL, 1); arm();
    @(posedge clk); #1;
    rst_n = 0;
    mark();
    lit("rstb_req", L_REQ, 0); lit("rstb_stall", L_STALL, 0); lit("rstb_be", L_OBE, 0);
    lit("rstb_addr", L_OADDR, 0); lit("rstb_mis", L_MIS, 0); lit("rstb_berr", L_BERR, 0);
    arm();
    @(posedge clk); #1;
    ex_valid = 0; ex_alu_result = 32'h0000_0042;
    @(posedge clk); #1;
    rst_n = 1;
    exp_stall = 0; exp_req = 0; exp_mis = 0; exp_berr = 0; exp_md_vld = 1; exp_md = 32'h42;
    chk_en = 1;
    mark(); run_op(1, 1, 0, 2'b10, 0, 32'h10, 0, 0, 32'h600D_CAFE, 2);
    lit("post_rst_data", L_MD, 32'h600D_CAFE); lit("post_rst_reqcyc", L_REQN, 2); arm();

    run_op(0, 0, 0, 2'b00, 0, 0, 0, 32'hE0D0_0000, 0, 0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
